// File: rtl/scene_painter_if.sv
// Pixel-job stream and descriptor-table write bus of the scene painter.
// The painter takes the master side; game logic and the fetch stage the slave.
interface scene_painter_if #(
  parameter int COOR_WIDTH    = 11,
  parameter int ELEMENT_WIDTH = 5
);
  logic                     desc_we;
  logic [ELEMENT_WIDTH-1:0] desc_addr;
  logic                     desc_enable;
  logic [COOR_WIDTH-1:0]    desc_sprite_x;
  logic [COOR_WIDTH-1:0]    desc_sprite_y;
  logic [COOR_WIDTH-1:0]    desc_frame_x;
  logic [COOR_WIDTH-1:0]    desc_frame_y;
  logic [COOR_WIDTH-1:0]    desc_width;
  logic [COOR_WIDTH-1:0]    desc_height;

  logic                     pix_valid;
  logic                     pix_ready;
  logic [COOR_WIDTH-1:0]    pix_x;
  logic [COOR_WIDTH-1:0]    pix_y;
  logic [COOR_WIDTH-1:0]    pix_sprite_x;
  logic [COOR_WIDTH-1:0]    pix_sprite_y;
  logic                     pix_is_bg;
  logic [ELEMENT_WIDTH-1:0] pix_index;

  modport master (
    input  desc_we, desc_addr, desc_enable,
    input  desc_sprite_x, desc_sprite_y,
    input  desc_frame_x, desc_frame_y,
    input  desc_width, desc_height,
    input  pix_ready,
    output pix_valid, pix_x, pix_y,
    output pix_sprite_x, pix_sprite_y,
    output pix_is_bg, pix_index
  );

  modport slave (
    output desc_we, desc_addr, desc_enable,
    output desc_sprite_x, desc_sprite_y,
    output desc_frame_x, desc_frame_y,
    output desc_width, desc_height,
    output pix_ready,
    input  pix_valid, pix_x, pix_y,
    input  pix_sprite_x, pix_sprite_y,
    input  pix_is_bg, pix_index
  );
endinterface

// File: rtl/scene_painter.sv
// Frame composer: background raster, then each enabled table element.
// Define SCENE_PAINTER_CLIP_EN to suppress element pixels outside the screen.
module scene_painter #(
  parameter int COOR_WIDTH    = 11,
  parameter int ELEMENT_COUNT = 32,
  parameter int ELEMENT_WIDTH = 5,
  parameter int SCREEN_W      = 1280,
  parameter int SCREEN_H      = 250
) (
  input  logic clk_33m,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  scene_painter_if.master bus
);
  localparam int CW = COOR_WIDTH;
  localparam int EW = ELEMENT_WIDTH;
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] XMAX  = CW'(SCREEN_W - 1);
  localparam logic [CW-1:0] YMAX  = CW'(SCREEN_H - 1);
  localparam logic [EW-1:0] E_ONE = EW'(1);
  localparam logic [EW-1:0] LAST  = EW'(ELEMENT_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE, BG, LOAD, ELEM, FIN
  } state_t;

  state_t state;

  logic          t_en [ELEMENT_COUNT];
  logic [CW-1:0] t_sx [ELEMENT_COUNT];
  logic [CW-1:0] t_sy [ELEMENT_COUNT];
  logic [CW-1:0] t_fx [ELEMENT_COUNT];
  logic [CW-1:0] t_fy [ELEMENT_COUNT];
  logic [CW-1:0] t_w  [ELEMENT_COUNT];
  logic [CW-1:0] t_h  [ELEMENT_COUNT];

  logic [EW-1:0] idx;
  logic [CW-1:0] dx, dy;
  logic [CW-1:0] w, h, fx, fy, sx, sy;

  logic          fire, step, skip;
  logic          bg_xend, bg_yend;
  logic          x_end, y_end;
  logic [CW-1:0] bnx, bny, nx, ny;
  logic          vis_first, vis_next;

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      for (int k = 0; k < ELEMENT_COUNT; k++) begin
        t_en[k] <= 1'b0;
        t_sx[k] <= '0;
        t_sy[k] <= '0;
        t_fx[k] <= '0;
        t_fy[k] <= '0;
        t_w[k]  <= '0;
        t_h[k]  <= '0;
      end
    end else if (bus.desc_we &&
                 int'(bus.desc_addr) < ELEMENT_COUNT) begin
      t_en[bus.desc_addr] <= bus.desc_enable;
      t_sx[bus.desc_addr] <= bus.desc_sprite_x;
      t_sy[bus.desc_addr] <= bus.desc_sprite_y;
      t_fx[bus.desc_addr] <= bus.desc_frame_x;
      t_fy[bus.desc_addr] <= bus.desc_frame_y;
      t_w[bus.desc_addr]  <= bus.desc_width;
      t_h[bus.desc_addr]  <= bus.desc_height;
    end
  end

  always_comb begin
    fire    = bus.pix_valid & bus.pix_ready;
    step    = fire | ~bus.pix_valid;
    skip    = ~t_en[idx] | (t_w[idx] == '0) |
              (t_h[idx] == '0);
    bg_xend = (dx == XMAX);
    bg_yend = (dy == YMAX);
    bnx     = bg_xend ? '0 : dx + ONE;
    bny     = bg_xend ? dy + ONE : dy;
    x_end   = (dx == w - ONE);
    y_end   = (dy == h - ONE);
    nx      = x_end ? '0 : dx + ONE;
    ny      = x_end ? dy + ONE : dy;
  end

`ifdef SCENE_PAINTER_CLIP_EN
  localparam logic [CW:0] SW = (CW+1)'(SCREEN_W);
  localparam logic [CW:0] SH = (CW+1)'(SCREEN_H);

  // One extra bit so a wrapped sum still reads as off-screen.
  logic [CW:0] nsx, nsy;
  always_comb begin
    nsx       = {1'b0, fx} + {1'b0, nx};
    nsy       = {1'b0, fy} + {1'b0, ny};
    vis_first = ({1'b0, t_fx[idx]} < SW) &&
                ({1'b0, t_fy[idx]} < SH);
    vis_next  = (nsx < SW) && (nsy < SH);
  end
`else
  always_comb begin
    vis_first = 1'b1;
    vis_next  = 1'b1;
  end
`endif

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      idx              <= '0;
      dx               <= '0;
      dy               <= '0;
      w                <= '0;
      h                <= '0;
      fx               <= '0;
      fy               <= '0;
      sx               <= '0;
      sy               <= '0;
      bus.pix_valid    <= 1'b0;
      bus.pix_x        <= '0;
      bus.pix_y        <= '0;
      bus.pix_sprite_x <= '0;
      bus.pix_sprite_y <= '0;
      bus.pix_is_bg    <= 1'b0;
      bus.pix_index    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          state            <= BG;
          busy             <= 1'b1;
          idx              <= '0;
          dx               <= '0;
          dy               <= '0;
          bus.pix_valid    <= 1'b1;
          bus.pix_x        <= '0;
          bus.pix_y        <= '0;
          bus.pix_sprite_x <= '0;
          bus.pix_sprite_y <= '0;
          bus.pix_is_bg    <= 1'b1;
          bus.pix_index    <= '0;
        end
        BG: if (fire) begin
          if (bg_xend && bg_yend) begin
            bus.pix_valid <= 1'b0;
            bus.pix_is_bg <= 1'b0;
            idx           <= '0;
            state         <= LOAD;
          end else begin
            dx        <= bnx;
            dy        <= bny;
            bus.pix_x <= bnx;
            bus.pix_y <= bny;
          end
        end
        LOAD: if (skip) begin
          if (idx == LAST) begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            idx <= idx + E_ONE;
          end
        end else begin
          // Descriptor is frozen here; later writes wait for next frame.
          w                <= t_w[idx];
          h                <= t_h[idx];
          fx               <= t_fx[idx];
          fy               <= t_fy[idx];
          sx               <= t_sx[idx];
          sy               <= t_sy[idx];
          dx               <= '0;
          dy               <= '0;
          bus.pix_valid    <= vis_first;
          bus.pix_x        <= t_fx[idx];
          bus.pix_y        <= t_fy[idx];
          bus.pix_sprite_x <= t_sx[idx];
          bus.pix_sprite_y <= t_sy[idx];
          bus.pix_is_bg    <= 1'b0;
          bus.pix_index    <= idx;
          state            <= ELEM;
        end
        ELEM: if (step) begin
          if (x_end && y_end) begin
            bus.pix_valid <= 1'b0;
            if (idx == LAST) begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx   <= idx + E_ONE;
              state <= LOAD;
            end
          end else begin
            dx               <= nx;
            dy               <= ny;
            bus.pix_valid    <= vis_next;
            bus.pix_x        <= fx + nx;
            bus.pix_y        <= fy + ny;
            bus.pix_sprite_x <= sx + nx;
            bus.pix_sprite_y <= sy + ny;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/scene_painter.md
Name: scene_painter

Overview:
Parametrised frame-composition sequencer for the game display. On each start pulse it rasters a background pass over the whole screen, then walks a writable element-descriptor table in index order and rasters each enabled element's rectangle. It emits one pixel job per cycle (frame coordinate plus sprite coordinate) on a valid/ready stream to the downstream sprite-fetch/framebuffer-write stage. The table is rewritten by game logic between or during frames.

Parameters:
COOR_WIDTH, 11, width of every coordinate and size field
ELEMENT_COUNT, 32, number of descriptor table entries
ELEMENT_WIDTH, 5, index width; ELEMENT_COUNT <= 2**ELEMENT_WIDTH
SCREEN_W, 1280, background pass width and clip bound in x
SCREEN_H, 250, background pass height and clip bound in y

Ports:
clk_33m  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse: begin a frame; ignored while busy
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when a frame completes
desc_we  in  1  table write strobe
desc_addr  in  ELEMENT_WIDTH  table entry index
desc_enable  in  1  entry painted when 1
desc_sprite_x, desc_sprite_y  in  COOR_WIDTH each  sprite-sheet origin
desc_frame_x, desc_frame_y  in  COOR_WIDTH each  screen origin
desc_width, desc_height  in  COOR_WIDTH each  rectangle size
pix_valid  out  1  pixel job present
pix_ready  in  1  downstream accepts the job
pix_x, pix_y  out  COOR_WIDTH each  screen coordinate
pix_sprite_x, pix_sprite_y  out  COOR_WIDTH each  sprite-sheet coordinate (0 for background)
pix_is_bg  out  1  job is a background pixel
pix_index  out  ELEMENT_WIDTH  source element index (0 for background)

Behaviour:
- Reset: clk_33m, rst synchronous active-high. All outputs 0. State IDLE. Every table entry cleared (enable=0, all fields 0). Reset mid-frame aborts the frame with no done pulse; pix_valid is 0 from the cycle after rst is sampled.
- States:
  - IDLE: waits for start.
  - BG: background raster.
  - LOAD: latches entry i.
  - ELEM: element raster.
  - FIN: drives done.
- IDLE -> BG on start. dx=dy=0, i=0.
- BG: emits SCREEN_W*SCREEN_H jobs in raster order, x fastest; pix_is_bg=1.
  - After the handshake on (SCREEN_W-1, SCREEN_H-1): -> LOAD.
- LOAD: takes one cycle per entry.
  - Entry disabled, or width==0, or height==0: skipped; i increments, or -> FIN after the last index.
  - Otherwise the descriptor is latched into working registers, dx=dy=0, -> ELEM.
- ELEM: emits jobs with
  - pix_x = frame_x+dx, pix_y = frame_y+dy
  - pix_sprite_x = sprite_x+dx, pix_sprite_y = sprite_y+dy
  - raster order, dx fastest.
  - After the handshake on (width-1, height-1): i++ -> LOAD, or -> FIN if i == ELEMENT_COUNT-1.
- FIN: done=1 for one cycle, busy drops in the same cycle, -> IDLE.
- Handshake:
  - A job transfers on pix_valid && pix_ready.
  - While pix_valid && !pix_ready, every pix_* output holds stable.
  - pix_valid is never withdrawn without a transfer.
  - Sustained throughput is 1 job/cycle with ready held high.
- Latency: first background job is valid the cycle after start is sampled.
- Arithmetic: sums are COOR_WIDTH modulo 2**COOR_WIDTH. Counters are COOR_WIDTH wide.
- Table writes:
  - Writes land at the clock edge and are accepted in any state.
  - The entry being painted was latched in LOAD, so a write to it mid-raster has no effect until the next frame.
  - A write to the entry being loaded in that same cycle: LOAD sees the old value.
  - desc_addr >= ELEMENT_COUNT: write ignored.
- start while busy is ignored. start in the FIN cycle is ignored. start coincident with rst is ignored.

Optional Feature:
SCENE_PAINTER_CLIP_EN.
- Defined:
  - Element pixels are tested for frame_x+dx >= SCREEN_W or frame_y+dy >= SCREEN_H, using a COOR_WIDTH+1-bit sum so overflow counts as outside.
  - Such pixels are suppressed: no pix_valid, and the counter advances one position per cycle.
  - An element wholly off-screen still takes width*height cycles and emits nothing.
- Undefined: all element pixels are emitted with wrapped coordinates.

Test Plan:
Bench parameters for all scenarios: SCREEN_W=8, SCREEN_H=4, ELEMENT_COUNT=4, ELEMENT_WIDTH=2, COOR_WIDTH=11.
1. Empty table, start, ready=1 -> 32 bg jobs (0,0)..(7,3) in raster order. Then LOAD scans 4 entries; done pulses exactly once; cycle from start to done is 1+32+4+1.
2. Entry 2 = {en=1, sprite 100,5, frame 3,1, w=2, h=2}, others disabled -> after bg, jobs (3,1)/(100,5), (4,1)/(101,5), (3,2)/(100,6), (4,2)/(101,6); pix_index=2; pix_is_bg=0.
3. Same as 2 with pix_ready toggled 1,0,0,1 repeatedly -> outputs hold stable during stalls; no job is duplicated or lost; the same 36 jobs are emitted.
4. Entry 0 = {frame 7,3, w=3, h=1}:
   - SCENE_PAINTER_CLIP_EN defined -> only (7,3) emitted.
   - Undefined -> (7,3), (8,3), (9,3).
   - frame_x=2046, w=3, undefined -> x values 2046, 2047, 0.
5. Mid-ELEM of scenario 2, write entry 2 frame_x=0 -> current frame finishes at x 3..4; next frame paints x 0..1. Entry with w=0, en=1 is skipped in one cycle.
6. rst asserted for 1 cycle mid-BG -> pix_valid=0, busy=0 next cycle; no done pulse; table reads back cleared (next frame emits bg only). A start asserted while busy changes nothing.
